polirv_fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined polirv core. It replaces direct combinational PC-to-instruction-memory addressing with a handshaked memory port that tolerates variable latency. Fetched instructions are buffered in a prefetch FIFO and handed to decode over valid/ready. The block supports PC redirect and flush from branch/jump resolution.

---
 rtl/polirv_fetch_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/polirv_fetch_unit.sv
// -----------------------------------------------------------------------------
// polirv_fetch_unit
//
// Instruction-fetch front end for the pipelined polirv core. Requests are
// issued to instruction memory over a req/ack handshake that tolerates any
// latency. At most one request is outstanding. Returned words are buffered in
// a small prefetch FIFO and handed to decode over valid/ready. A redirect from
// branch/jump resolution flushes the FIFO and restarts fetch at a new PC.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_mem_req/addr      registered fetch request (held until ack)
//   i_mem_ack/data      memory response for the outstanding request
//   redirect_valid/pc   flush and restart fetch at redirect_pc
//   out_valid/ready     head-of-FIFO handshake towards decode
//   out_instr/out_pc    head instruction and its PC
//   fifo_count          number of occupied FIFO entries
//
// Optional build macro POLIRV_FETCH_STATS_EN adds two free-running counters:
//   stat_fetched        instructions pushed into the FIFO
//   stat_flushed        FIFO entries discarded by redirects plus dropped acks
// -----------------------------------------------------------------------------
module polirv_fetch_unit #(
  parameter int                     I_ADDR_BITS = 6,
  parameter int                     FIFO_DEPTH  = 4,
  parameter logic [I_ADDR_BITS-1:0] RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          i_mem_req,
  output logic [I_ADDR_BITS-1:0]        i_mem_addr,
  input  logic                          i_mem_ack,
  input  logic [31:0]                   i_mem_data,
  input  logic                          redirect_valid,
  input  logic [I_ADDR_BITS-1:0]        redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [I_ADDR_BITS-1:0]        out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef POLIRV_FETCH_STATS_EN
  ,
  output logic [31:0]                   stat_fetched,
  output logic [31:0]                   stat_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = I_ADDR_BITS + 32;
  localparam logic [I_ADDR_BITS-1:0] PC_STEP   = I_ADDR_BITS'(4);
  localparam logic [CNT_W-1:0]       DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [I_ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [I_ADDR_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ENT_W-1:0]       buf_q [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic [CNT_W-1:0]       count_nx;
  logic [I_ADDR_BITS-1:0] pc_inc;

  // Head is hidden during a redirect so decode never consumes a flushed entry.
  assign out_valid  = (count_q != '0) && !redirect_valid;
  assign out_instr  = buf_q[rd_ptr_q][31:0];
  assign out_pc     = buf_q[rd_ptr_q][ENT_W-1:32];
  assign fifo_count = count_q;
  assign i_mem_req  = req_q;
  assign i_mem_addr = req_addr_q;

  assign pop      = out_valid & out_ready;
  assign push     = (state_q == S_WAIT) && i_mem_ack && !redirect_valid;
  assign count_nx = count_q + CNT_W'(push) - CNT_W'(pop);
  assign pc_inc   = fetch_pc_q + PC_STEP;  // wraps modulo 2^I_ADDR_BITS

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_nx;

    unique case (state_q)
      S_IDLE: begin
        // Only launch when the FIFO is guaranteed to have room for the ack.
        if (!redirect_valid && (count_nx < DEPTH_CNT)) begin
          state_d    = S_WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // An ack in the redirect cycle is simply discarded.
          state_d = i_mem_ack ? S_IDLE : S_DROP;
        end else if (i_mem_ack) begin
          if (count_nx < DEPTH_CNT) begin
            req_addr_d = pc_inc;  // back-to-back request
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // Request address must stay put until memory answers the stale request.
        if (i_mem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fetch_pc_d = pc_inc;
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  assign req_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= {fetch_pc_q, i_mem_data};
    end
  end

`ifdef POLIRV_FETCH_STATS_EN
  logic        drop_ack;
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  // A response is dropped when it lands in DROP or coincides with a redirect.
  assign drop_ack = i_mem_ack &&
                    ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect_valid));

  always_comb begin
    fetched_d = fetched_q + 32'(push);
    flushed_d = flushed_q + (redirect_valid ? 32'(count_q) : 32'd0) + 32'(drop_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule
